// File: rtl/divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, quotient or remainder.
// One quotient bit per clock; handshake mirrors the shift-add multiplier.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             enable_i,
  input  logic             rem_or_quo_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] Result,
  output logic             ready_o,
  output logic             div_by_zero_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXECUTE = 2'b01,
    FIXUP   = 2'b10,
    OUTPUT  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       cnt;
  logic             last;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_raw;
  logic             rq;
  logic             a_neg;
  logic             q_neg;
  logic             zero;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Partial remainder stays below the divisor, so 32 bits plus the shifted-in
  // quotient bit cover every trial subtraction.
  assign r_sh = {rem, quo[WIDTH-1]};
  assign diff = r_sh - {1'b0, dvs};

  assign a_mag = (sign_i & A_i[WIDTH-1]) ? -A_i : A_i;
  assign b_mag = (sign_i & B_i[WIDTH-1]) ? -B_i : B_i;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable_i) state_nxt = EXECUTE;
      EXECUTE: if (last && cnt == 5'd31) state_nxt = FIXUP;
      FIXUP:   state_nxt = OUTPUT;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      last          <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      a_raw         <= '0;
      rq            <= 1'b0;
      a_neg         <= 1'b0;
      q_neg         <= 1'b0;
      zero          <= 1'b0;
      Result        <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          last <= 1'b0;
          if (enable_i) begin
            rq    <= rem_or_quo_i;
            a_neg <= A_i[WIDTH-1] & sign_i;
            q_neg <= (A_i[WIDTH-1] ^ B_i[WIDTH-1]) & sign_i;
            zero  <= (B_i == '0);
            a_raw <= A_i;
            quo   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
          end
        end
        EXECUTE: begin
          // The cycle after bit 31 is a settle cycle with the counter parked.
          if (!last) begin
            rem <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            if (cnt == 5'd31) last <= 1'b1;
            else              cnt  <= cnt + 5'd1;
          end
        end
        FIXUP: begin
          if (q_neg) quo <= -quo;
          if (a_neg) rem <= -rem;
        end
        OUTPUT: begin
          ready_o       <= 1'b1;
          div_by_zero_o <= zero;
          if (zero) Result <= rq ? a_raw : '1;
          else      Result <= rq ? rem : quo;
        end
        default: ;
      endcase
    end
  end

endmodule
